// File: rtl/keyboard_scan_if.sv
// Keypad scanner signal bundle: scan control, pad pins and debounced key outputs.
// The scanner connects through the slave modport and the consumer through the master modport.
// The key_release member exists only when KEYBOARD_SCAN_RELEASE_EN is defined.
interface keyboard_scan_if;
  logic        scan_en;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] key_state;
  logic [15:0] key_pulse;
`ifdef KEYBOARD_SCAN_RELEASE_EN
  logic [15:0] key_release;

  modport master (output scan_en, col_n, input row_n, key_state, key_pulse, key_release);
  modport slave  (input scan_en, col_n, output row_n, key_state, key_pulse, key_release);
`else
  modport master (output scan_en, col_n, input row_n, key_state, key_pulse);
  modport slave  (input scan_en, col_n, output row_n, key_state, key_pulse);
`endif
endinterface

// File: rtl/keyboard_scan.sv
// 4x4 keypad scanner: drives the rows one at a time, synchronizes the columns,
// debounces each key and emits single-clock press pulses.
// Optional feature macro: KEYBOARD_SCAN_RELEASE_EN adds single-clock release pulses.

// Per-key debouncer. A sample that differs from the held level bumps the
// counter; DEBOUNCE_SCANS differing samples in a row flip the level.
module keyboard_scan_key #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic clr,
  input  logic s,
  output logic state,
  output logic pulse
`ifdef KEYBOARD_SCAN_RELEASE_EN
  ,
  output logic fall
`endif
);
  logic [3:0] cnt;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt + 4'd1;

  // Debounce counter, debounced level and edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      state <= 1'b0;
      pulse <= 1'b0;
`ifdef KEYBOARD_SCAN_RELEASE_EN
      fall  <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
`ifdef KEYBOARD_SCAN_RELEASE_EN
      fall  <= 1'b0;
`endif
      if (clr) begin
        cnt <= '0;
      end else if (sample) begin
        if (s == state) begin
          cnt <= '0;
        end else if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
          state <= s;
          cnt   <= '0;
          pulse <= s;
`ifdef KEYBOARD_SCAN_RELEASE_EN
          fall  <= ~s;
`endif
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end
endmodule

module keyboard_scan #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic           clk,
  input logic           rst,
  keyboard_scan_if.slave bus
);
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int SW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SETTLE_CYCLES < 4) begin : g_bad_settle
    $error("keyboard_scan: SETTLE_CYCLES must be 4 or more");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
    $error("keyboard_scan: DEBOUNCE_SCANS must be 1..15");
  end

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t                  state;
  logic [1:0]              row_idx;
  logic [SW-1:0]           settle_cnt;
  logic [NUM_ROWS-1:0]     row_n_q;
  logic [1:0][NUM_COLS-1:0] col_pipe;
  logic [NUM_COLS-1:0]     col_s;
  logic                    settle_last;
  logic                    sample;
  logic                    cnt_clr;
  logic [NUM_KEYS-1:0]     key_sample;
  logic [NUM_KEYS-1:0]     key_s;
  logic [NUM_KEYS-1:0]     key_state_w;
  logic [NUM_KEYS-1:0]     key_pulse_w;
`ifdef KEYBOARD_SCAN_RELEASE_EN
  logic [NUM_KEYS-1:0]     key_fall_w;
`endif

  // Two-flop column synchronizer; resets to the released (pulled-up) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) col_pipe <= {2{{NUM_COLS{1'b1}}}};
    else     col_pipe <= {col_pipe[0], bus.col_n};
  end

  assign col_s       = ~col_pipe[1];
  assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  // The last settle cycle of a row is its sample cycle; never sample while disabled.
  assign sample      = (state == DRIVE) && bus.scan_en && settle_last;
  // Dropping the enable abandons any partial debounce history.
  assign cnt_clr     = ~bus.scan_en;

  // Row sequencer: IDLE until enabled, then each row for SETTLE_CYCLES clocks, back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row_idx    <= '0;
      settle_cnt <= '0;
      row_n_q    <= '1;
    end else if (!bus.scan_en) begin
      state      <= IDLE;
      row_idx    <= '0;
      settle_cnt <= '0;
      row_n_q    <= '1;
    end else begin
      case (state)
        IDLE: begin
          state      <= DRIVE;
          row_idx    <= '0;
          settle_cnt <= '0;
          row_n_q    <= 4'b1110;
        end
        DRIVE: begin
          if (settle_last) begin
            settle_cnt <= '0;
            row_idx    <= row_idx + 2'd1;
            row_n_q    <= ~(4'b0001 << (row_idx + 2'd1));
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the sample strobe to the four keys of the row being driven.
  always_comb begin
    key_sample = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      key_sample[k] = sample && (row_idx == 2'(k / NUM_COLS));
  end

  // Key k sees column k%4.
  assign key_s = {NUM_ROWS{col_s}};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    keyboard_scan_key #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_key (
      .clk    (clk),
      .rst    (rst),
      .sample (key_sample[k]),
      .clr    (cnt_clr),
      .s      (key_s[k]),
      .state  (key_state_w[k]),
      .pulse  (key_pulse_w[k])
`ifdef KEYBOARD_SCAN_RELEASE_EN
      ,
      .fall   (key_fall_w[k])
`endif
    );
  end

  assign bus.row_n       = row_n_q;
  assign bus.key_state   = key_state_w;
  assign bus.key_pulse   = key_pulse_w;
`ifdef KEYBOARD_SCAN_RELEASE_EN
  assign bus.key_release = key_fall_w;
`endif
endmodule
